// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, select and state encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational state/mem_ready to control-word decoder
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]  i_state,
    input  logic        i_mem_ready,
    input  logic [5:0]  i_opcode,
    output ctrl_word_t  o_cw
);

    always_comb begin
        o_cw = '0;
        case (i_state)
            S_FETCH: begin
                o_cw.mem_read  = 1'b1;
                o_cw.alu_src_b = SRCB_FOUR;
                o_cw.alu_op    = ALUOP_ADD;
                o_cw.pc_source = PCSRC_ALU;
                // IR and PC+4 commit only in the cycle the read completes
                o_cw.ir_write  = i_mem_ready;
                o_cw.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_cw.alu_src_b  = SRCB_IMM_SH2;
                o_cw.alu_op     = ALUOP_ADD;
                o_cw.illegal_op = !op_supported(i_opcode);
                o_cw.instr_done = !op_supported(i_opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_IMM;
                o_cw.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_cw.iord     = 1'b1;
                o_cw.mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.mem_to_reg = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_cw.iord       = 1'b1;
                o_cw.mem_write  = 1'b1;
                o_cw.instr_done = i_mem_ready;
            end
            S_EXEC: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_REGB;
                o_cw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.reg_dst    = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_cw.alu_src_a     = 1'b1;
                o_cw.alu_src_b     = SRCB_REGB;
                o_cw.alu_op        = ALUOP_SUB;
                o_cw.pc_source     = PCSRC_ALUOUT;
                o_cw.pc_write_cond = 1'b1;
                o_cw.instr_done    = 1'b1;
            end
            S_ADDIWB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            S_JUMP: begin
                o_cw.pc_source  = PCSRC_JUMP;
                o_cw.pc_write   = 1'b1;
                o_cw.instr_done = 1'b1;
            end
            default: o_cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS datapath sequencer: state register and next-state logic
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t     r_state;
    state_t     w_next;
    ctrl_word_t w_cw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RST;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .i_opcode    (opcode),
        .o_cw        (w_cw)
    );

    assign PCWrite     = w_cw.pc_write;
    assign PCWriteCond = w_cw.pc_write_cond;
    assign IorD        = w_cw.iord;
    assign MemRead     = w_cw.mem_read;
    assign MemWrite    = w_cw.mem_write;
    assign IRWrite     = w_cw.ir_write;
    assign MemtoReg    = w_cw.mem_to_reg;
    assign RegDst      = w_cw.reg_dst;
    assign RegWrite    = w_cw.reg_write;
    assign ALUSrcA     = w_cw.alu_src_a;
    assign ALUSrcB     = w_cw.alu_src_b;
    assign ALUOp       = w_cw.alu_op;
    assign PCSource    = w_cw.pc_source;
    assign instr_done  = w_cw.instr_done;
    assign illegal_op  = w_cw.illegal_op;
    assign state       = STATE_W'(r_state);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a shared multi-cycle MIPS datapath: one ALU, one memory port, IR, PC and register file.
- Decodes the IR opcode, then drives ALUOp into the existing ALU-control decoder plus all mux selects and write enables, one micro-step per clock.
- Memory steps stall on a ready handshake from the memory port.
- Supports R-type, lw, sw, beq, j and addi.

Parameters:
- STATE_W, 4, width of state register and debug state output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26]; stable from DECODE until the next FETCH.
- mem_ready  input  1  memory port has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU Zero (branch).
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load IR from memory data.
- MemtoReg  output  1  register write-data select: 1=MDR, 0=ALUOut.
- RegDst  output  1  destination register select: 1=rd, 0=rt.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A select: 0=PC, 1=regA.
- ALUSrcB  output  2  ALU B select: 00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  output  2  to ALU-control decoder: 00=add, 01=sub, 10=use funct.
- PCSource  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported.
- state  output  STATE_W  current state, debug only.

Behaviour:
Reset:
- rst_n=0 forces state=RST immediately (asynchronous).
- In RST every output is 0; any in-flight memory access is abandoned.
- First rising edge after release: RST->FETCH.

States, with non-zero outputs listed (all unlisted outputs are 0):
- RST(0): none -> FETCH.
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (Mealy).
  - Holds while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other: illegal_op=1, instr_done=1 -> FETCH.
- MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD if lw, MEMWR if sw.
- MEMRD(4): IorD=1, MemRead=1; holds until mem_ready=1 -> MEMWB.
- MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
- MEMWR(6): IorD=1, MemWrite=1; holds until mem_ready=1, then instr_done=1 -> FETCH.
- EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB(8): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1, instr_done=1 -> FETCH.
- ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB(11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
- JUMP(12): PCSource=10, PCWrite=1, instr_done=1 -> FETCH.
- Encodings 13-15: unreachable; if entered, all outputs 0 -> FETCH.

Latency, with mem_ready tied to 1:
- R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles, counted from FETCH.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Handshake rules:
- MemRead/MemWrite stay asserted and the address select stays stable for every stall cycle.
- mem_ready is ignored in all other states.
- MemRead and MemWrite are never both 1 in the same cycle.

Other invariants:
- PCWrite and PCWriteCond are never both 1 in the same cycle.
- Outputs are combinational from state (plus mem_ready where noted), so there is no output register latency.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUOp encodings;
  - ALUSrcB and PCSource encodings;
  - the state encoding constants.
- One natural sub-module: multicycle_ctrl_decode, a pure combinational state+mem_ready -> control-word decoder. The top holds the state register and next-state logic.

Test Plan:
- Reset + R-type: rst_n low 2 cycles, opcode=000000, mem_ready=1 -> all outputs 0 during reset; states 1,2,7,8; RegWrite=1, RegDst=1 in cycle 4; instr_done pulses once.
- lw with stall: opcode=100011, mem_ready=0 for 2 cycles in MEMRD -> MemRead=1, IorD=1 held 3 cycles; MEMWB asserts RegWrite=1, MemtoReg=1; total 7 cycles.
- sw then beq back-to-back, mem_ready=1:
  - sw takes 4 cycles, MemWrite=1 only in MEMWR.
  - beq takes 3 cycles, PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH -> IRWrite=PCWrite=0 while stalled, both 1 only in the cycle mem_ready rises.
- Illegal + jump: opcode=111111 -> illegal_op=1 in DECODE, back to FETCH, 2 cycles total. Then opcode=000010 -> JUMP with PCWrite=1, PCSource=10.
- Reset mid-MEMWR: rst_n low while MemWrite=1 -> MemWrite drops to 0 the same cycle without waiting for a clock edge; state=0; after release, resumes at FETCH.
